// File: rtl/poly_voice_controller_if.sv
// Purpose: note-event, envelope-config and mixed-audio signals of poly_voice_controller.
// Latency: none, this is wiring only.
// Backpressure: none. Events are single-cycle strobes, outputs are free-running registers.
// Ports: master drives events/config and observes audio; slave is the controller itself.
interface poly_voice_controller_if #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int AMP_W      = 16,
    parameter int OUT_W      = 20
);
    logic                  note_on;
    logic                  note_off;
    logic [3:0]            note;
    logic [2:0]            octave;
    logic [PHASE_W-1:0]    phase_inc;
    logic                  env_tick;
    logic [AMP_W-1:0]      amp_max;
    logic [AMP_W-1:0]      attack_step;
    logic [AMP_W-1:0]      decay_step;
    logic [AMP_W-1:0]      sustain_level;
    logic [AMP_W-1:0]      release_step;
    logic [OUT_W-1:0]      wave_out;
    logic [NUM_VOICES-1:0] voices_active;
    logic                  voice_stolen;

    modport master (
        output note_on, note_off, note, octave, phase_inc, env_tick,
               amp_max, attack_step, decay_step, sustain_level, release_step,
        input  wave_out, voices_active, voice_stolen
    );

    modport slave (
        input  note_on, note_off, note, octave, phase_inc, env_tick,
               amp_max, attack_step, decay_step, sustain_level, release_step,
        output wave_out, voices_active, voice_stolen
    );
endinterface

// File: rtl/poly_voice_controller.sv
// Purpose: polyphonic note allocator with per-voice square oscillator, linear ADSR and saturating mixer.
// Latency: one clk from a note event or env_tick to wave_out / voices_active / voice_stolen.
// Backpressure: none. Every event is accepted; when all voices are busy one is stolen round-robin.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries note events, envelope
//        config, wave_out, voices_active and voice_stolen.
module poly_voice_controller #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int AMP_W      = 16,
    parameter int OUT_W      = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    poly_voice_controller_if.slave bus
);
    localparam int KEY_W = 7;
    localparam int IDX_W = $clog2(NUM_VOICES);
    // Sum width keeps a full unsigned env magnitude plus sign, plus growth for N voices.
    localparam int MAG_W = (OUT_W > AMP_W + 1) ? OUT_W : AMP_W + 1;
    localparam int SUM_W = MAG_W + IDX_W;

    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } voice_state_t;

    voice_state_t          state_q [NUM_VOICES];
    logic [AMP_W-1:0]      env_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
    logic [KEY_W-1:0]      key_q   [NUM_VOICES];
    logic [IDX_W-1:0]      steal_ptr_q;
    logic [OUT_W-1:0]      wave_out_q;
    logic [NUM_VOICES-1:0] voices_active_q;
    logic                  voice_stolen_q;

    voice_state_t          state_n [NUM_VOICES];
    logic [AMP_W-1:0]      env_n   [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_n [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_n   [NUM_VOICES];
    logic [KEY_W-1:0]      key_n   [NUM_VOICES];
    logic [IDX_W-1:0]      steal_ptr_n;
    logic [OUT_W-1:0]      wave_out_n;
    logic [NUM_VOICES-1:0] voices_active_n;

    logic [KEY_W-1:0]      ev_key;
    logic [AMP_W-1:0]      sus_lvl;
    logic                  retrig_hit;
    logic [IDX_W-1:0]      retrig_idx;
    logic                  idle_hit;
    logic [IDX_W-1:0]      idle_idx;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  do_steal;
    logic signed [SUM_W-1:0] mag;
    logic signed [SUM_W-1:0] mix_sum;

    // Allocation is decided on the current registered state, before any same-cycle note_off.
    always_comb begin
        ev_key     = {bus.octave, bus.note};
        sus_lvl    = (bus.sustain_level > bus.amp_max) ? bus.amp_max : bus.sustain_level;
        retrig_hit = 1'b0;
        retrig_idx = '0;
        idle_hit   = 1'b0;
        idle_idx   = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (state_q[i] != ST_IDLE && key_q[i] == ev_key) begin
                retrig_hit = 1'b1;
                retrig_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_IDLE) begin
                idle_hit = 1'b1;
                idle_idx = IDX_W'(i);
            end
        end
        alloc_idx   = retrig_hit ? retrig_idx : (idle_hit ? idle_idx : steal_ptr_q);
        do_steal    = bus.note_on && !retrig_hit && !idle_hit;
        steal_ptr_n = steal_ptr_q;
        if (do_steal) begin
            steal_ptr_n = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + IDX_W'(1);
        end
    end

    // Per-voice next state. Precedence: envelope tick, then note_off, then note_on.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            state_n[i] = state_q[i];
            env_n[i]   = env_q[i];
            phase_n[i] = phase_q[i];
            inc_n[i]   = inc_q[i];
            key_n[i]   = key_q[i];

            if (state_q[i] != ST_IDLE) begin
                phase_n[i] = phase_q[i] + inc_q[i];
            end

            if (bus.env_tick) begin
                case (state_q[i])
                    ST_ATTACK: begin
                        if (env_q[i] >= bus.amp_max || bus.attack_step >= bus.amp_max - env_q[i]) begin
                            env_n[i]   = bus.amp_max;
                            state_n[i] = ST_DECAY;
                        end else begin
                            env_n[i] = env_q[i] + bus.attack_step;
                        end
                    end
                    ST_DECAY: begin
                        if (env_q[i] <= sus_lvl || env_q[i] - sus_lvl <= bus.decay_step) begin
                            env_n[i]   = sus_lvl;
                            state_n[i] = ST_SUSTAIN;
                        end else begin
                            env_n[i] = env_q[i] - bus.decay_step;
                        end
                    end
                    ST_SUSTAIN: begin
                        env_n[i] = sus_lvl;
                    end
                    ST_RELEASE: begin
                        if (env_q[i] <= bus.release_step) begin
                            env_n[i]   = '0;
                            state_n[i] = ST_IDLE;
                        end else begin
                            env_n[i] = env_q[i] - bus.release_step;
                        end
                    end
                    default: ;
                endcase
            end

            if (bus.note_off && key_q[i] == ev_key &&
                (state_q[i] == ST_ATTACK || state_q[i] == ST_DECAY || state_q[i] == ST_SUSTAIN)) begin
                state_n[i] = ST_RELEASE;
            end

            if (bus.note_on && alloc_idx == IDX_W'(i)) begin
                state_n[i] = ST_ATTACK;
                inc_n[i]   = bus.phase_inc;
                if (retrig_hit) begin
                    // Retrigger restarts the attack from wherever the envelope is now.
                    env_n[i]   = env_q[i];
                    phase_n[i] = phase_q[i];
                end else begin
                    key_n[i]   = ev_key;
                    env_n[i]   = '0;
                    phase_n[i] = '0;
                end
            end

            if (state_n[i] == ST_IDLE) begin
                phase_n[i] = '0;
            end
        end
    end

    // Mixer works on post-edge voice values so wave_out is one clk behind the event.
    always_comb begin
        mix_sum = '0;
        mag     = '0;
        voices_active_n = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voices_active_n[i] = (state_n[i] != ST_IDLE);
            mag = SUM_W'(env_n[i]);
            if (state_n[i] != ST_IDLE) begin
                if (phase_n[i][PHASE_W-1]) begin
                    mix_sum = mix_sum - mag;
                end else begin
                    mix_sum = mix_sum + mag;
                end
            end
        end
        if (mix_sum > OUT_MAX) begin
            wave_out_n = OUT_MAX[OUT_W-1:0];
        end else if (mix_sum < OUT_MIN) begin
            wave_out_n = OUT_MIN[OUT_W-1:0];
        end else begin
            wave_out_n = mix_sum[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= ST_IDLE;
                env_q[i]   <= '0;
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                key_q[i]   <= '0;
            end
            steal_ptr_q     <= '0;
            wave_out_q      <= '0;
            voices_active_q <= '0;
            voice_stolen_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= state_n[i];
                env_q[i]   <= env_n[i];
                phase_q[i] <= phase_n[i];
                inc_q[i]   <= inc_n[i];
                key_q[i]   <= key_n[i];
            end
            steal_ptr_q     <= steal_ptr_n;
            wave_out_q      <= wave_out_n;
            voices_active_q <= voices_active_n;
            voice_stolen_q  <= do_steal;
        end
    end

    assign bus.wave_out      = wave_out_q;
    assign bus.voices_active = voices_active_q;
    assign bus.voice_stolen  = voice_stolen_q;
endmodule
